// File: rtl/robo_navegador_param.sv
// rtl/robo_navegador_param.sv - wall-following debris robot controller, Moore FSM with
// stuck detection, burst-length control and saturating telemetry counters.
module robo_navegador_param #(
    parameter int ENTULHO_CICLOS = 4,
    parameter int GIROS_MAX      = 4,
    parameter int PASSOS_W       = 16,
    parameter int ENT_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                head,
    input  logic                left,
    input  logic                under,
    input  logic                barrier,
    output logic                avancar,
    output logic                girar,
    output logic                recolher_entulho,
    output logic                travado,
    output logic [2:0]          estado,
    output logic [PASSOS_W-1:0] passos,
    output logic [ENT_W-1:0]    entulhos
);

    localparam int GW = $clog2(GIROS_MAX + 1);
    localparam int EW = $clog2(ENTULHO_CICLOS + 1);

    typedef enum logic [2:0] {
        PARADO       = 3'd0,
        AVANCANDO    = 3'd1,
        ROTACIONANDO = 3'd2,
        RETIRANDO    = 3'd3,
        GIRANDO      = 3'd4,
        TRAVADO      = 3'd5
    } estado_t;

    estado_t             state_q, state_d;
    logic [GW-1:0]       cnt_giro_q, cnt_giro_d;
    logic [EW-1:0]       cnt_ent_q, cnt_ent_d;
    logic [PASSOS_W-1:0] passos_q, passos_d;
    logic [ENT_W-1:0]    entulhos_q, entulhos_d;
    logic                burst_done;

    always_comb begin
        state_d    = state_q;
        cnt_giro_d = '0;
        cnt_ent_d  = '0;
        burst_done = 1'b0;

        if (!enable) begin
            state_d = PARADO;
        end else if (under && state_q != TRAVADO) begin
            state_d = PARADO;
        end else begin
            case (state_q)
                PARADO, GIRANDO: begin
                    if (barrier)   state_d = RETIRANDO;
                    else if (head) state_d = ROTACIONANDO;
                    else           state_d = AVANCANDO;
                end
                AVANCANDO: begin
                    if (barrier)    state_d = RETIRANDO;
                    else if (head)  state_d = ROTACIONANDO;
                    else if (!left) state_d = GIRANDO;
                    else            state_d = AVANCANDO;
                end
                ROTACIONANDO: begin
                    if (barrier)
                        state_d = RETIRANDO;
                    else if (!head)
                        state_d = AVANCANDO;
                    else if (cnt_giro_q == GW'(GIROS_MAX - 1))
                        state_d = TRAVADO;
                    else begin
                        state_d    = ROTACIONANDO;
                        cnt_giro_d = cnt_giro_q + GW'(1);
                    end
                end
                RETIRANDO: begin
                    if (cnt_ent_q == EW'(ENTULHO_CICLOS - 1)) begin
                        burst_done = 1'b1;
                        if (barrier)   state_d = RETIRANDO;
                        else if (head) state_d = ROTACIONANDO;
                        else           state_d = AVANCANDO;
                    end else begin
                        state_d   = RETIRANDO;
                        cnt_ent_d = cnt_ent_q + EW'(1);
                    end
                end
                TRAVADO: state_d = TRAVADO;
                default: state_d = PARADO;
            endcase
        end

        passos_d = passos_q;
        if (state_q == AVANCANDO && passos_q != {PASSOS_W{1'b1}})
            passos_d = passos_q + PASSOS_W'(1);

        entulhos_d = entulhos_q;
        if (burst_done && entulhos_q != {ENT_W{1'b1}})
            entulhos_d = entulhos_q + ENT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= PARADO;
            cnt_giro_q <= '0;
            cnt_ent_q  <= '0;
            passos_q   <= '0;
            entulhos_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_giro_q <= cnt_giro_d;
            cnt_ent_q  <= cnt_ent_d;
            passos_q   <= passos_d;
            entulhos_q <= entulhos_d;
        end
    end

    assign avancar          = (state_q == AVANCANDO);
    assign girar            = (state_q == ROTACIONANDO) || (state_q == GIRANDO);
    assign recolher_entulho = (state_q == RETIRANDO);
    assign travado          = (state_q == TRAVADO);
    assign estado           = state_q;
    assign passos           = passos_q;
    assign entulhos         = entulhos_q;

endmodule

// File: tb/tb_robo_navegador_param.sv
// tb/tb_robo_navegador_param.sv - directed bench for robo_navegador_param.
module tb_robo_navegador_param;

    logic        clock = 1'b0;
    logic        reset, enable, head, left, under, barrier;
    logic        avancar, girar, recolher_entulho, travado;
    logic [2:0]  estado;
    logic [15:0] passos;
    logic [7:0]  entulhos;

    logic        reset2;
    logic        avancar2, girar2, recolher2, travado2;
    logic [2:0]  estado2;
    logic [3:0]  passos2;
    logic [7:0]  entulhos2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    robo_navegador_param dut (
        .clock(clock), .reset(reset), .enable(enable), .head(head), .left(left),
        .under(under), .barrier(barrier), .avancar(avancar), .girar(girar),
        .recolher_entulho(recolher_entulho), .travado(travado), .estado(estado),
        .passos(passos), .entulhos(entulhos)
    );

    robo_navegador_param #(.PASSOS_W(4)) dut_small (
        .clock(clock), .reset(reset2), .enable(1'b1), .head(1'b0), .left(1'b1),
        .under(1'b0), .barrier(1'b0), .avancar(avancar2), .girar(girar2),
        .recolher_entulho(recolher2), .travado(travado2), .estado(estado2),
        .passos(passos2), .entulhos(entulhos2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] cmds();
        return {avancar, girar, recolher_entulho, travado};
    endfunction

    initial begin
        reset = 1'b1; enable = 1'b0; head = 1'b0; left = 1'b1; under = 1'b0; barrier = 1'b0;
        reset2 = 1'b1;
        step(3);
        check_eq("rst_cmds", {28'd0, cmds()}, 32'd0);
        check_eq("rst_estado", {29'd0, estado}, 32'd0);
        check_eq("rst_passos", {16'd0, passos}, 32'd0);
        check_eq("rst_entulhos", {24'd0, entulhos}, 32'd0);

        reset = 1'b0; enable = 1'b1;
        step(1);
        check_eq("adv_first_cmds", {28'd0, cmds()}, 32'b1000);
        check_eq("adv_first_passos", {16'd0, passos}, 32'd0);
        step(9);
        check_eq("adv_passos9", {16'd0, passos}, 32'd9);
        check_eq("adv_still", {31'd0, avancar}, 32'd1);

        left = 1'b0;
        step(1);
        left = 1'b1;
        check_eq("girando_cmds", {28'd0, cmds()}, 32'b0100);
        check_eq("girando_estado", {29'd0, estado}, 32'd4);
        step(1);
        check_eq("post_gir_cmds", {28'd0, cmds()}, 32'b1000);
        check_eq("post_gir_passos", {16'd0, passos}, 32'd10);

        barrier = 1'b1;
        step(1);
        barrier = 1'b0;
        check_eq("burst_c1", {28'd0, cmds()}, 32'b0010);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("burst_hold", {28'd0, cmds()}, 32'b0010);
        end
        step(1);
        check_eq("burst_end_cmds", {28'd0, cmds()}, 32'b1000);
        check_eq("burst_end_ent", {24'd0, entulhos}, 32'd1);

        barrier = 1'b1;
        step(5);
        check_eq("b2b_ent2", {24'd0, entulhos}, 32'd2);
        check_eq("b2b_state", {29'd0, estado}, 32'd3);
        step(4);
        check_eq("b2b_ent3", {24'd0, entulhos}, 32'd3);
        barrier = 1'b0;
        step(4);
        check_eq("b2b_end_ent", {24'd0, entulhos}, 32'd4);
        check_eq("b2b_end_cmds", {28'd0, cmds()}, 32'b1000);
        check_eq("b2b_passos", {16'd0, passos}, 32'd12);

        head = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_eq("rot_girar", {28'd0, cmds()}, 32'b0100);
        end
        step(1);
        check_eq("stuck_cmds", {28'd0, cmds()}, 32'b0001);
        check_eq("stuck_estado", {29'd0, estado}, 32'd5);
        under = 1'b1;
        step(5);
        under = 1'b0;
        check_eq("stuck_holds", {28'd0, cmds()}, 32'b0001);
        enable = 1'b0;
        step(1);
        head = 1'b0;
        check_eq("disable_estado", {29'd0, estado}, 32'd0);
        check_eq("disable_cmds", {28'd0, cmds()}, 32'd0);
        check_eq("rot_passos", {16'd0, passos}, 32'd13);

        enable = 1'b1;
        step(1);
        barrier = 1'b1;
        step(1);
        barrier = 1'b0;
        step(1);
        check_eq("abort_in_burst", {28'd0, cmds()}, 32'b0010);
        under = 1'b1;
        step(1);
        check_eq("abort_estado", {29'd0, estado}, 32'd0);
        check_eq("abort_ent", {24'd0, entulhos}, 32'd4);
        under = 1'b0;
        step(1);
        check_eq("restart_cmds", {28'd0, cmds()}, 32'b1000);

        under = 1'b1; barrier = 1'b1;
        step(1);
        check_eq("under_wins", {29'd0, estado}, 32'd0);
        under = 1'b0; head = 1'b1;
        step(1);
        check_eq("barrier_over_head", {29'd0, estado}, 32'd3);
        head = 1'b0; barrier = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_eq("midburst_rst_estado", {29'd0, estado}, 32'd0);
        check_eq("midburst_rst_passos", {16'd0, passos}, 32'd0);
        check_eq("midburst_rst_ent", {24'd0, entulhos}, 32'd0);

        reset2 = 1'b0;
        step(1);
        check_eq("sat_first", {31'd0, avancar2}, 32'd1);
        step(20);
        check_eq("sat_passos", {28'd0, passos2}, 32'd15);
        step(3);
        check_eq("sat_held", {28'd0, passos2}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
